sa_round_sequencer: RTL and testbench
=====================================

# sa_round_sequencer

Job-level scheduler above the systolic-array controller path. It takes a start pulse plus job geometry (filter size, weight rounds, feature words per round) and runs each round in order: clear, weight load, feature stream, drain, result capture. While it runs it drives the weight-memory, feature-memory and array-level control strobes, then signals completion. It sits between the host/top-level and the systolic array with its memories.

## Interface
- N_ROWS_ARRAY, 4, rows in array (documentation/width checks only)
- N, 3, max filter dimension
- COUNTER_ROUND_WIDTH, 3, round counter width (round field is COUNTER_ROUND_WIDTH+1 bits)
- INPUT_FEATURE_ADDR_WIDTH, 5, feature memory address width
- WEIGHT_ADDR_WIDTH, 6, weight memory address width
- DRAIN_CYCLES, 4, pipeline flush cycles after last feature (≥1)

Ports:
- clk_i  in  1  single clock, rising edge
- general_rst_i  in  1  asynchronous, active-high reset
- start_i  in  1  job start pulse; sampled only in IDLE
- abort_i  in  1  synchronous abort
- filter_size_i  in  $clog2(N+1)  weight words per round; latched at start
- n_round_weight_i  in  COUNTER_ROUND_WIDTH+1  rounds per job; latched at start
- n_feature_i  in  INPUT_FEATURE_ADDR_WIDTH+1  feature words per round; latched at start
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle completion pulse
- array_rst_o  out  1  array clear strobe
- rd_weight_rst_o  out  1  weight register clear
- rd_weight_ld_o  out  1  weight register load enable
- weight_addr_o  out  WEIGHT_ADDR_WIDTH  weight memory address
- load_o  out  1  array weight-load phase
- rd_feature_ld_o  out  1  feature memory read enable
- in_feature_addr_o  out  INPUT_FEATURE_ADDR_WIDTH  feature address
- start_op_o  out  1  array compute enable
- result_valid_o  out  1  result_o of the array valid this cycle
- round_o  out  COUNTER_ROUND_WIDTH+1  current round index

## Operation
- States: IDLE, CLEAR, WLOAD, STREAM, DRAIN, RESULT, DONE. Outputs are a Moore decode of registered state and counters.
- IDLE + start_i: latch the three geometry inputs and set round=0. Go to CLEAR; if n_round_weight_i==0, go to DONE instead. start_i outside IDLE is ignored.
- CLEAR (1 cycle): array_rst_o=1, rd_weight_rst_o=1. In_feature_addr is cleared. Next state is WLOAD, or STREAM if filter_size==0.
- WLOAD (filter_size cycles): load_o=1, rd_weight_ld_o=1. weight_addr_o increments after each cycle. It does not reset between rounds and wraps modulo 2^WEIGHT_ADDR_WIDTH. Next state is STREAM, or DRAIN if n_feature==0.
- STREAM (n_feature cycles): rd_feature_ld_o=1, start_op_o=1. in_feature_addr_o counts 0..n_feature-1; n_feature=32 wraps to 0 on exit.
- DRAIN (DRAIN_CYCLES cycles): start_op_o=1.
- RESULT (1 cycle): result_valid_o=1. If round==n_round-1, go to DONE; else round+1 and go to CLEAR.
- DONE (1 cycle): done_o=1, then IDLE. weight_addr_o is held; it resets only on general_rst_i.
- abort_i in any non-IDLE state: IDLE next cycle with no done_o. Counters are not cleared, except round, which is cleared. abort_i has priority over normal transitions.
- Reset values: all outputs 0, state IDLE, all counters 0.
- Reset mid-job: outputs go to 0 asynchronously. No done_o follows the reset.

## Timing
- start_i sampled at edge k → CLEAR is active in cycle k+1.
- Round length R = 1 + F + NF + DRAIN_CYCLES + 1.
- done_o is high in cycle k+1+n_round·R. busy_o falls in the cycle after done_o.
- n_round=0: done_o in cycle k+1.
- Memory addresses are valid in the same cycle as their read enable. Memories register data one cycle later; that latency is accounted for by DRAIN_CYCLES.
- start_i coincident with done_o is ignored, because the FSM is in DONE and not IDLE.

## Structure
- Shared package sparhixcel_pkg: state enum `sa_seq_state_t` and the width constants (COUNTER_ROUND_WIDTH, INPUT_FEATURE_ADDR_WIDTH, WEIGHT_ADDR_WIDTH).
- One sub-module, `phase_counter`: loadable down-counter with zero flag. It is reused for WLOAD, STREAM and DRAIN length counting; the FSM stays in the top module.

## Test plan
- F=3, NF=8, D=4, 1 round, start at k:
  - CLEAR at k+1; WLOAD k+2..k+4 with weight_addr 0,1,2; STREAM k+5..k+12 with addr 0..7.
  - DRAIN k+13..k+16; result_valid_o at k+17; done_o at k+18.
- Same geometry, 2 rounds:
  - Round 2 weight_addr continues 3,4,5; in_feature_addr restarts at 0.
  - round_o=1 in round 2; done_o at k+35.
- n_round=0: done_o at k+1 and no other strobes. Separately, F=0, NF=0: each round is CLEAR→DRAIN→RESULT, 6 cycles.
- abort_i in the 3rd STREAM cycle: IDLE next cycle, busy_o=0, no done_o. A new start_i then runs cleanly from CLEAR.
- general_rst_i asserted asynchronously mid-WLOAD: all outputs 0 before the next edge. After release, weight_addr_o=0 and there is no spurious done_o.
- start_i pulsed during STREAM and during DONE: ignored; the job timing is unchanged.

Source files
------------

// File: rtl/sparhixcel_pkg.sv
// Shared state encoding and width constants for the systolic-array job sequencer.
package sparhixcel_pkg;

    localparam int COUNTER_ROUND_WIDTH      = 3;
    localparam int INPUT_FEATURE_ADDR_WIDTH = 5;
    localparam int WEIGHT_ADDR_WIDTH        = 6;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_WLOAD  = 3'd2,
        S_STREAM = 3'd3,
        S_DRAIN  = 3'd4,
        S_RESULT = 3'd5,
        S_DONE   = 3'd6
    } sa_seq_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sa_round_sequencer_phase_counter.sv
// Loadable down-counter with zero flag; times the WLOAD, STREAM and DRAIN phases.
module phase_counter
    import sparhixcel_pkg::*;
#(
    parameter int W = 6
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_ld,
    input  logic [W-1:0] i_ld_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    // Load wins over decrement; the count parks at zero.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_ld) begin
            r_cnt <= i_ld_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/sa_round_sequencer.sv
// Job-level round scheduler for the systolic array: per weight round it runs
// clear, weight load, feature stream, drain and result capture, then signals done.
module sa_round_sequencer
    import sparhixcel_pkg::*;
#(
    parameter int N_ROWS_ARRAY             = 4,
    parameter int N                        = 3,
    parameter int COUNTER_ROUND_WIDTH      = sparhixcel_pkg::COUNTER_ROUND_WIDTH,
    parameter int INPUT_FEATURE_ADDR_WIDTH = sparhixcel_pkg::INPUT_FEATURE_ADDR_WIDTH,
    parameter int WEIGHT_ADDR_WIDTH        = sparhixcel_pkg::WEIGHT_ADDR_WIDTH,
    parameter int DRAIN_CYCLES             = 4
) (
    input  logic                                clk_i,
    input  logic                                general_rst_i,
    input  logic                                start_i,
    input  logic                                abort_i,
    input  logic [$clog2(N+1)-1:0]              filter_size_i,
    input  logic [COUNTER_ROUND_WIDTH:0]        n_round_weight_i,
    input  logic [INPUT_FEATURE_ADDR_WIDTH:0]   n_feature_i,
    output logic                                busy_o,
    output logic                                done_o,
    output logic                                array_rst_o,
    output logic                                rd_weight_rst_o,
    output logic                                rd_weight_ld_o,
    output logic [WEIGHT_ADDR_WIDTH-1:0]        weight_addr_o,
    output logic                                load_o,
    output logic                                rd_feature_ld_o,
    output logic [INPUT_FEATURE_ADDR_WIDTH-1:0] in_feature_addr_o,
    output logic                                start_op_o,
    output logic                                result_valid_o,
    output logic [COUNTER_ROUND_WIDTH:0]        round_o
);

    localparam int FW    = $clog2(N + 1);
    localparam int RW    = COUNTER_ROUND_WIDTH + 1;
    localparam int NFW   = INPUT_FEATURE_ADDR_WIDTH + 1;
    localparam int DW    = $clog2(DRAIN_CYCLES + 1);
    localparam int CNT_W = max_int(max_int(FW, NFW), DW);

    if (N_ROWS_ARRAY < 1 || N < 1 || DRAIN_CYCLES < 1) begin : g_cfg_check
        $error("sa_round_sequencer: N_ROWS_ARRAY, N and DRAIN_CYCLES must all be >= 1");
    end

    sa_seq_state_t                       r_state;
    sa_seq_state_t                       w_state_nxt;
    logic [FW-1:0]                       r_filter;
    logic [RW-1:0]                       r_nround;
    logic [NFW-1:0]                      r_nfeat;
    logic [RW-1:0]                       r_round;
    logic [WEIGHT_ADDR_WIDTH-1:0]        r_waddr;
    logic [INPUT_FEATURE_ADDR_WIDTH-1:0] r_faddr;

    logic             w_cnt_ld;
    logic             w_cnt_dec;
    logic [CNT_W-1:0] w_cnt_val;
    logic             w_cnt_zero;
    logic             w_latch;
    logic             w_round_clr;
    logic             w_round_inc;
    logic             w_waddr_inc;
    logic             w_faddr_inc;
    logic             w_faddr_clr;
    logic [CNT_W-1:0] w_ld_f;
    logic [CNT_W-1:0] w_ld_nf;
    logic [CNT_W-1:0] w_ld_d;
    logic             w_last_round;

    // Phase lengths are loaded as length-1 so the zero flag marks the final cycle.
    assign w_ld_f       = CNT_W'(r_filter) - CNT_W'(1);
    assign w_ld_nf      = CNT_W'(r_nfeat) - CNT_W'(1);
    assign w_ld_d       = CNT_W'(DRAIN_CYCLES - 1);
    assign w_last_round = ((r_round + RW'(1)) == r_nround);

    phase_counter #(
        .W(CNT_W)
    ) u_phase_counter (
        .i_clk    (clk_i),
        .i_rst    (general_rst_i),
        .i_ld     (w_cnt_ld),
        .i_ld_val (w_cnt_val),
        .i_dec    (w_cnt_dec),
        .o_zero   (w_cnt_zero)
    );

    always_ff @(posedge clk_i or posedge general_rst_i) begin
        if (general_rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_ld        = 1'b0;
        w_cnt_val       = '0;
        w_cnt_dec       = 1'b0;
        w_latch         = 1'b0;
        w_round_clr     = 1'b0;
        w_round_inc     = 1'b0;
        w_waddr_inc     = 1'b0;
        w_faddr_inc     = 1'b0;
        w_faddr_clr     = 1'b0;
        busy_o          = (r_state != S_IDLE);
        done_o          = 1'b0;
        array_rst_o     = 1'b0;
        rd_weight_rst_o = 1'b0;
        rd_weight_ld_o  = 1'b0;
        load_o          = 1'b0;
        rd_feature_ld_o = 1'b0;
        start_op_o      = 1'b0;
        result_valid_o  = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_latch     = 1'b1;
                    w_round_clr = 1'b1;
                    w_state_nxt = (n_round_weight_i == '0) ? S_DONE : S_CLEAR;
                end
            end
            S_CLEAR: begin
                array_rst_o     = 1'b1;
                rd_weight_rst_o = 1'b1;
                w_faddr_clr     = 1'b1;
                w_cnt_ld        = 1'b1;
                if (r_filter != '0) begin
                    w_cnt_val   = w_ld_f;
                    w_state_nxt = S_WLOAD;
                end else if (r_nfeat != '0) begin
                    w_cnt_val   = w_ld_nf;
                    w_state_nxt = S_STREAM;
                end else begin
                    w_cnt_val   = w_ld_d;
                    w_state_nxt = S_DRAIN;
                end
            end
            S_WLOAD: begin
                load_o         = 1'b1;
                rd_weight_ld_o = 1'b1;
                w_waddr_inc    = 1'b1;
                if (w_cnt_zero) begin
                    w_cnt_ld = 1'b1;
                    if (r_nfeat != '0) begin
                        w_cnt_val   = w_ld_nf;
                        w_state_nxt = S_STREAM;
                    end else begin
                        w_cnt_val   = w_ld_d;
                        w_state_nxt = S_DRAIN;
                    end
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            S_STREAM: begin
                rd_feature_ld_o = 1'b1;
                start_op_o      = 1'b1;
                w_faddr_inc     = 1'b1;
                if (w_cnt_zero) begin
                    w_cnt_ld    = 1'b1;
                    w_cnt_val   = w_ld_d;
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            S_DRAIN: begin
                start_op_o = 1'b1;
                if (w_cnt_zero) begin
                    w_state_nxt = S_RESULT;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            S_RESULT: begin
                result_valid_o = 1'b1;
                if (w_last_round) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_round_inc = 1'b1;
                    w_state_nxt = S_CLEAR;
                end
            end
            S_DONE: begin
                done_o      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Abort drops the job immediately; only the round index is rewound.
        if (abort_i && (r_state != S_IDLE)) begin
            w_state_nxt = S_IDLE;
            w_round_clr = 1'b1;
            w_round_inc = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge general_rst_i) begin
        if (general_rst_i) begin
            r_filter <= '0;
            r_nround <= '0;
            r_nfeat  <= '0;
            r_round  <= '0;
            r_waddr  <= '0;
            r_faddr  <= '0;
        end else begin
            if (w_latch) begin
                r_filter <= filter_size_i;
                r_nround <= n_round_weight_i;
                r_nfeat  <= n_feature_i;
            end
            if (w_round_clr) begin
                r_round <= '0;
            end else if (w_round_inc) begin
                r_round <= r_round + RW'(1);
            end
            if (w_waddr_inc) begin
                r_waddr <= r_waddr + WEIGHT_ADDR_WIDTH'(1);
            end
            if (w_faddr_clr) begin
                r_faddr <= '0;
            end else if (w_faddr_inc) begin
                r_faddr <= r_faddr + INPUT_FEATURE_ADDR_WIDTH'(1);
            end
        end
    end

    assign weight_addr_o     = r_waddr;
    assign in_feature_addr_o = r_faddr;
    assign round_o           = r_round;

endmodule

// File: tb/tb_sa_round_sequencer.sv
// Bench for sa_round_sequencer: a job-schedule model checked every cycle, plus
// hand-computed cycle pins for the directed scenarios.
module tb_sa_round_sequencer;

    localparam int FS_W  = 2;
    localparam int RND_W = 4;
    localparam int NF_W  = 6;
    localparam int FA_W  = 5;
    localparam int WA_W  = 6;
    localparam int DRAIN = 4;

    logic              clk_i = 1'b0;
    logic              general_rst_i;
    logic              start_i;
    logic              abort_i;
    logic [FS_W-1:0]   filter_size_i;
    logic [RND_W-1:0]  n_round_weight_i;
    logic [NF_W-1:0]   n_feature_i;
    logic              busy_o;
    logic              done_o;
    logic              array_rst_o;
    logic              rd_weight_rst_o;
    logic              rd_weight_ld_o;
    logic [WA_W-1:0]   weight_addr_o;
    logic              load_o;
    logic              rd_feature_ld_o;
    logic [FA_W-1:0]   in_feature_addr_o;
    logic              start_op_o;
    logic              result_valid_o;
    logic [RND_W-1:0]  round_o;

    sa_round_sequencer #(
        .N_ROWS_ARRAY(4), .N(3), .COUNTER_ROUND_WIDTH(3),
        .INPUT_FEATURE_ADDR_WIDTH(5), .WEIGHT_ADDR_WIDTH(6), .DRAIN_CYCLES(DRAIN)
    ) dut (
        .clk_i(clk_i), .general_rst_i(general_rst_i), .start_i(start_i), .abort_i(abort_i),
        .filter_size_i(filter_size_i), .n_round_weight_i(n_round_weight_i), .n_feature_i(n_feature_i),
        .busy_o(busy_o), .done_o(done_o), .array_rst_o(array_rst_o), .rd_weight_rst_o(rd_weight_rst_o),
        .rd_weight_ld_o(rd_weight_ld_o), .weight_addr_o(weight_addr_o), .load_o(load_o),
        .rd_feature_ld_o(rd_feature_ld_o), .in_feature_addr_o(in_feature_addr_o),
        .start_op_o(start_op_o), .result_valid_o(result_valid_o), .round_o(round_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tot = 0;
    int n_bad = 0;
    int t     = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (time %0t)", nm, act, exp, $time);
        end
    endtask

    // Expected view of one cycle of outputs.
    typedef struct {
        int busy, done, arst, wrst, wld, load, fld, sop, rv;
        int round, waddr, faddr;
    } exp_t;

    exp_t cur;
    exp_t q[$];
    int   m_w     = 0;
    int   m_round = 0;

    function automatic exp_t blank(input int busy, input int round);
        exp_t e;
        e.busy = busy; e.done = 0; e.arst = 0; e.wrst = 0; e.wld = 0; e.load = 0;
        e.fld = 0; e.sop = 0; e.rv = 0; e.round = round; e.waddr = m_w; e.faddr = 0;
        return e;
    endfunction

    // Expand a whole job into its per-cycle output schedule.
    task automatic build_job(input int f, input int nf, input int nr);
        exp_t e;
        if (nr == 0) begin
            m_round = 0;
            e = blank(1, 0); e.done = 1; q.push_back(e);
            return;
        end
        for (int r = 0; r < nr; r++) begin
            e = blank(1, r); e.arst = 1; e.wrst = 1; q.push_back(e);
            for (int j = 0; j < f; j++) begin
                e = blank(1, r); e.load = 1; e.wld = 1; q.push_back(e);
                m_w = (m_w + 1) % 64;
            end
            for (int j = 0; j < nf; j++) begin
                e = blank(1, r); e.fld = 1; e.sop = 1; e.faddr = j % 32; q.push_back(e);
            end
            for (int j = 0; j < DRAIN; j++) begin
                e = blank(1, r); e.sop = 1; q.push_back(e);
            end
            e = blank(1, r); e.rv = 1; q.push_back(e);
        end
        m_round = nr - 1;
        e = blank(1, nr - 1); e.done = 1; q.push_back(e);
    endtask

    always @(posedge clk_i or posedge general_rst_i) begin
        if (general_rst_i) begin
            q.delete(); m_w = 0; m_round = 0; cur = blank(0, 0);
        end else if (cur.busy == 1 && abort_i) begin
            q.delete(); m_w = (cur.waddr + cur.wld) % 64; m_round = 0; cur = blank(0, 0);
        end else if (cur.busy == 0 && start_i) begin
            build_job(int'(filter_size_i), int'(n_feature_i), int'(n_round_weight_i));
            cur = q.pop_front();
        end else if (q.size() > 0) begin
            cur = q.pop_front();
        end else begin
            cur = blank(0, m_round);
        end
    end

    always @(negedge clk_i) begin
        chk("busy", int'(busy_o), cur.busy);
        chk("done", int'(done_o), cur.done);
        chk("array_rst", int'(array_rst_o), cur.arst);
        chk("rd_weight_rst", int'(rd_weight_rst_o), cur.wrst);
        chk("rd_weight_ld", int'(rd_weight_ld_o), cur.wld);
        chk("load", int'(load_o), cur.load);
        chk("rd_feature_ld", int'(rd_feature_ld_o), cur.fld);
        chk("start_op", int'(start_op_o), cur.sop);
        chk("result_valid", int'(result_valid_o), cur.rv);
        chk("round", int'(round_o), cur.round);
        chk("weight_addr", int'(weight_addr_o), cur.waddr);
        if (cur.fld == 1) chk("feature_addr", int'(in_feature_addr_o), cur.faddr);
    end

    task automatic adv(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #2;
        end
        t += n;
    endtask

    task automatic start_job(input int f, input int nf, input int nr);
        filter_size_i    = FS_W'(f);
        n_feature_i      = NF_W'(nf);
        n_round_weight_i = RND_W'(nr);
        start_i          = 1'b1;
        adv(1);
        start_i = 1'b0;
        t = 1;
    endtask

    task automatic wait_done(input int limit, output int off);
        int w;
        w = 0;
        while (done_o !== 1'b1 && w < limit) begin
            adv(1);
            w++;
        end
        off = (done_o === 1'b1) ? t : -1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int off;
        general_rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0;
        filter_size_i = '0; n_round_weight_i = '0; n_feature_i = '0;
        @(posedge clk_i); #2;
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_done", int'(done_o), 0);
        chk("rst_waddr", int'(weight_addr_o), 0);
        chk("rst_round", int'(round_o), 0);
        @(posedge clk_i); #2;
        general_rst_i = 1'b0;
        adv(2);

        // F=3, NF=8, one round
        start_job(3, 8, 1);
        chk("t1_clear", int'(array_rst_o), 1);
        adv(1); chk("t1_wl_first", int'(weight_addr_o), 0); chk("t1_load", int'(load_o), 1);
        adv(2); chk("t1_wl_last", int'(weight_addr_o), 2);
        adv(1); chk("t1_st_first", int'(in_feature_addr_o), 0); chk("t1_fld", int'(rd_feature_ld_o), 1);
        adv(7); chk("t1_st_last", int'(in_feature_addr_o), 7);
        adv(1); chk("t1_drain_sop", int'(start_op_o), 1); chk("t1_drain_fld", int'(rd_feature_ld_o), 0);
        adv(4); chk("t1_result", int'(result_valid_o), 1);
        wait_done(40, off); chk("t1_done_cycle", off, 18);
        adv(1); chk("t1_idle", int'(busy_o), 0);
        adv(2);

        // zero rounds: straight to DONE
        start_job(2, 3, 0);
        chk("nr0_done", int'(done_o), 1); chk("nr0_busy", int'(busy_o), 1);
        chk("nr0_noclear", int'(array_rst_o), 0);
        adv(1); chk("nr0_idle", int'(busy_o), 0);
        adv(2);

        // F=0, NF=0, two rounds of six cycles
        start_job(0, 0, 2);
        chk("f0_clear", int'(array_rst_o), 1);
        adv(1); chk("f0_drain", int'(start_op_o), 1); chk("f0_noload", int'(load_o), 0);
        adv(4); chk("f0_result", int'(result_valid_o), 1);
        adv(1); chk("f0_clear2", int'(array_rst_o), 1); chk("f0_round2", int'(round_o), 1);
        wait_done(40, off); chk("f0_done_cycle", off, 13);
        adv(3);

        // abort in the third STREAM cycle, then a clean job
        start_job(3, 8, 1);
        adv(6); chk("ab_in_stream", int'(rd_feature_ld_o), 1);
        abort_i = 1'b1;
        adv(1); abort_i = 1'b0;
        chk("ab_busy", int'(busy_o), 0); chk("ab_done", int'(done_o), 0); chk("ab_round", int'(round_o), 0);
        adv(4);
        start_job(1, 2, 1);
        chk("ab2_clear", int'(array_rst_o), 1);
        adv(1); chk("ab2_waddr", int'(weight_addr_o), 6);
        wait_done(40, off); chk("ab2_done_cycle", off, 10);
        adv(3);

        // asynchronous reset in the middle of WLOAD
        start_job(3, 8, 1);
        adv(2); chk("rs_in_wload", int'(load_o), 1);
        #1 general_rst_i = 1'b1;
        #1;
        chk("rs_busy", int'(busy_o), 0); chk("rs_load", int'(load_o), 0);
        chk("rs_wld", int'(rd_weight_ld_o), 0); chk("rs_waddr", int'(weight_addr_o), 0);
        @(posedge clk_i); #2;
        general_rst_i = 1'b0;
        chk("rs_after_waddr", int'(weight_addr_o), 0);
        adv(25); chk("rs_no_done", int'(done_o), 0);

        // two rounds with start pulses during STREAM and DONE
        start_job(3, 8, 2);
        adv(1); chk("r2_w0", int'(weight_addr_o), 0);
        adv(4);
        filter_size_i = FS_W'(1); n_feature_i = NF_W'(2); n_round_weight_i = RND_W'(1);
        start_i = 1'b1;
        adv(1); start_i = 1'b0;
        adv(11); chk("r2_round_clr", int'(round_o), 1); chk("r2_clear2", int'(array_rst_o), 1);
        adv(1); chk("r2_w3", int'(weight_addr_o), 3);
        adv(2); chk("r2_w5", int'(weight_addr_o), 5);
        adv(1); chk("r2_f0", int'(in_feature_addr_o), 0); chk("r2_fld", int'(rd_feature_ld_o), 1);
        wait_done(40, off); chk("r2_done_cycle", off, 35);
        start_i = 1'b1;
        adv(1); start_i = 1'b0;
        chk("r2_idle", int'(busy_o), 0);
        adv(4); chk("r2_still_idle", int'(busy_o), 0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
